// File: rtl/ps2_command_sender.sv
// ps2_command_sender: host-to-device PS/2 transmitter (request-to-send, 8 data bits,
// odd parity, stop, ACK check) driving open-drain ps2_clock/ps2_data.
module ps2_command_sender #(
    parameter int INHIBIT_CYCLES       = 5500,
    parameter int REQUEST_CYCLES       = 50,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int XFER_TIMEOUT_CYCLES  = 100000
) (
    input  logic       inclock,
    input  logic       resetn,
    input  logic [7:0] command,
    input  logic       send_command,
    inout  wire        ps2_clock,
    inout  wire        ps2_data,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);
    localparam int CMAX = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
                          ((INHIBIT_CYCLES > REQUEST_CYCLES) ? INHIBIT_CYCLES : REQUEST_CYCLES) :
                          ((START_TIMEOUT_CYCLES > REQUEST_CYCLES) ? START_TIMEOUT_CYCLES : REQUEST_CYCLES);
    localparam int CW = $clog2(CMAX + 1);
    localparam int TW = $clog2(XFER_TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, WAIT_FIRST, XFER, WAIT_IDLE, DONE, ERROR} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [TW-1:0] tmr_q;
    logic [3:0]    bit_q;
    logic [9:0]    sh_q;
    logic          clk_en_q, dat_en_q, busy_q, sent_q, err_q;
    logic [2:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          fall, tmo;

    // Enables are the only driven quantity; a logical 1 is always high-Z.
    assign ps2_clock = clk_en_q ? 1'b0 : 1'bz;
    assign ps2_data  = dat_en_q ? 1'b0 : 1'bz;

    assign busy                          = busy_q;
    assign command_was_sent              = sent_q;
    assign error_communication_timed_out = err_q;

    assign fall = clk_sync_q[2] & ~clk_sync_q[1];
    assign tmo  = tmr_q == TW'(XFER_TIMEOUT_CYCLES - 1);

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clock};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
        end
    end

    // The shift register refills with ones so the stop bit and everything after it release the line.
    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tmr_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            clk_en_q <= 1'b0;
            dat_en_q <= 1'b0;
            busy_q   <= 1'b0;
            sent_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sent_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: if (send_command) begin
                    sh_q     <= {1'b1, ~^command, command};
                    cnt_q    <= '0;
                    clk_en_q <= 1'b1;
                    busy_q   <= 1'b1;
                    state_q  <= INHIBIT;
                end
                INHIBIT: if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    cnt_q    <= '0;
                    dat_en_q <= 1'b1;
                    state_q  <= REQUEST;
                end else cnt_q <= cnt_q + 1'b1;
                REQUEST: if (cnt_q == CW'(REQUEST_CYCLES - 1)) begin
                    cnt_q    <= '0;
                    clk_en_q <= 1'b0;
                    state_q  <= WAIT_FIRST;
                end else cnt_q <= cnt_q + 1'b1;
                WAIT_FIRST: if (fall) begin
                    bit_q    <= 4'd1;
                    tmr_q    <= '0;
                    dat_en_q <= ~sh_q[0];
                    sh_q     <= {1'b1, sh_q[9:1]};
                    state_q  <= XFER;
                end else if (cnt_q == CW'(START_TIMEOUT_CYCLES - 1)) begin
                    dat_en_q <= 1'b0;
                    err_q    <= 1'b1;
                    state_q  <= ERROR;
                end else cnt_q <= cnt_q + 1'b1;
                XFER: begin
                    tmr_q <= tmr_q + 1'b1;
                    if (fall) begin
                        bit_q    <= bit_q + 1'b1;
                        dat_en_q <= ~sh_q[0];
                        sh_q     <= {1'b1, sh_q[9:1]};
                    end
                    if (fall && bit_q == 4'd10) begin
                        err_q   <= dat_sync_q[1];
                        state_q <= dat_sync_q[1] ? ERROR : WAIT_IDLE;
                    end else if (tmo) begin
                        dat_en_q <= 1'b0;
                        err_q    <= 1'b1;
                        state_q  <= ERROR;
                    end
                end
                WAIT_IDLE: begin
                    tmr_q <= tmr_q + 1'b1;
                    if (clk_sync_q[1] && dat_sync_q[1]) begin
                        sent_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (tmo) begin
                        err_q   <= 1'b1;
                        state_q <= ERROR;
                    end
                end
                default: begin
                    clk_en_q <= 1'b0;
                    dat_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_command_sender.sv
// tb_ps2_command_sender: keyboard-side model that clocks frames, records the bits it
// reads on rising edges, and checks them plus the status pulses against a frame model.
module tb_ps2_command_sender;
    localparam int INHIBIT  = 5500;
    localparam int REQUEST  = 50;
    localparam int START_TO = 1000;
    localparam int XFER_TO  = 2000;

    logic       inclock = 1'b0;
    logic       resetn = 1'b0;
    logic       send_command = 1'b0;
    logic [7:0] command = 8'h00;
    wire        ps2_clock, ps2_data;
    logic       busy, command_was_sent, error_communication_timed_out;
    logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0;
    int         errors = 0, checks = 0, sent_cnt = 0, err_cnt = 0, overlap = 0;

    pullup pu_clk (ps2_clock);
    pullup pu_dat (ps2_data);
    assign ps2_clock = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_data  = dev_dat_low ? 1'b0 : 1'bz;

    always #10 inclock = ~inclock;

    ps2_command_sender #(
        .INHIBIT_CYCLES(INHIBIT),
        .REQUEST_CYCLES(REQUEST),
        .START_TIMEOUT_CYCLES(START_TO),
        .XFER_TIMEOUT_CYCLES(XFER_TO)
    ) dut (
        .inclock(inclock),
        .resetn(resetn),
        .command(command),
        .send_command(send_command),
        .ps2_clock(ps2_clock),
        .ps2_data(ps2_data),
        .busy(busy),
        .command_was_sent(command_was_sent),
        .error_communication_timed_out(error_communication_timed_out)
    );

    always @(negedge inclock) begin
        if (command_was_sent) sent_cnt++;
        if (error_communication_timed_out) err_cnt++;
        if (command_was_sent && error_communication_timed_out) overlap++;
    end

    // Line values the device reads: 8 data bits LSB first, odd parity, stop = 1.
    function automatic logic [9:0] frame_bits(input logic [7:0] c);
        int cv, ones;
        logic [9:0] f;
        cv = int'(c);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = (cv >> i) % 2 == 1;
            ones += (cv >> i) % 2;
        end
        f[8] = ones % 2 == 0;
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] c);
        @(negedge inclock);
        command = c;
        send_command = 1'b1;
        @(negedge inclock);
        send_command = 1'b0;
    endtask

    task automatic device_run(input int n_edges, input logic ack_low, output logic [9:0] seen, output logic ok);
        int n;
        seen = '0;
        ok = 1'b1;
        n = 0;
        while (!(ps2_clock === 1'b1 && ps2_data === 1'b0) && n < 8000) begin
            n++;
            @(negedge inclock);
        end
        if (n >= 8000) begin
            ok = 1'b0;
            return;
        end
        repeat (10) @(negedge inclock);
        for (int e = 1; e <= n_edges; e++) begin
            int half;
            half = int'($urandom_range(8, 20));
            if (e == 11) begin
                dev_dat_low = ack_low;
                repeat (2) @(negedge inclock);
            end
            dev_clk_low = 1'b1;
            repeat (half) @(negedge inclock);
            if (e <= 10) seen[e-1] = ps2_data;
            dev_clk_low = 1'b0;
            repeat (half) @(negedge inclock);
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge inclock);
        checks++;
        if ({busy, command_was_sent, error_communication_timed_out} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got busy/sent/err=%b want 000", {busy, command_was_sent, error_communication_timed_out});
        end
        checks++;
        if ({ps2_clock, ps2_data} !== 2'b11) begin
            errors++;
            $display("FAIL reset_lines: got clk/data=%b want 11", {ps2_clock, ps2_data});
        end
        resetn = 1'b1;
        repeat (3) @(negedge inclock);
    endtask

    task automatic test_command(input logic [7:0] c, input bit measure);
        logic [9:0] seen, exp_bits;
        logic ok;
        int n, s0, e0;
        exp_bits = frame_bits(c);
        s0 = sent_cnt;
        e0 = err_cnt;
        send(c);
        if (measure) begin
            n = 0;
            while (ps2_clock === 1'b0 && ps2_data === 1'b1 && n < 10000) begin
                n++;
                @(negedge inclock);
            end
            checks++;
            if (n != INHIBIT) begin
                errors++;
                $display("FAIL inhibit_len cmd=%h: got %0d cycles want %0d", c, n, INHIBIT);
            end
            n = 0;
            while (ps2_clock === 1'b0 && ps2_data === 1'b0 && n < 1000) begin
                n++;
                @(negedge inclock);
            end
            checks++;
            if (n != REQUEST) begin
                errors++;
                $display("FAIL request_len cmd=%h: got %0d cycles want %0d", c, n, REQUEST);
            end
        end
        device_run(11, 1'b1, seen, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL request_seen cmd=%h: got no request want request", c);
        end
        checks++;
        if (seen !== exp_bits) begin
            errors++;
            $display("FAIL frame cmd=%h: got %b want %b (stop..bit0)", c, seen, exp_bits);
        end
        n = 0;
        while (sent_cnt == s0 && err_cnt == e0 && n < 500) begin
            n++;
            @(negedge inclock);
        end
        repeat (3) @(negedge inclock);
        checks++;
        if (sent_cnt - s0 != 1 || err_cnt != e0) begin
            errors++;
            $display("FAIL success_pulse cmd=%h: got sent=%0d err=%0d want sent=1 err=0", c, sent_cnt - s0, err_cnt - e0);
        end
        checks++;
        if ({busy, ps2_clock, ps2_data} !== 3'b011) begin
            errors++;
            $display("FAIL idle_after cmd=%h: got busy/clk/data=%b want 011", c, {busy, ps2_clock, ps2_data});
        end
    endtask

    task automatic test_random;
        repeat (2) test_command(8'($urandom), 1'b0);
    endtask

    task automatic test_start_timeout;
        int n, m, s0, e0;
        s0 = sent_cnt;
        e0 = err_cnt;
        send(8'hF4);
        n = 0;
        while (!(ps2_clock === 1'b1 && ps2_data === 1'b0) && n < 10000) begin
            n++;
            @(negedge inclock);
        end
        m = 0;
        while (error_communication_timed_out !== 1'b1 && m < 3000) begin
            m++;
            @(negedge inclock);
        end
        checks++;
        if (m != START_TO) begin
            errors++;
            $display("FAIL start_timeout_len: got %0d cycles want %0d", m, START_TO);
        end
        repeat (2) @(negedge inclock);
        checks++;
        if (err_cnt - e0 != 1 || sent_cnt != s0) begin
            errors++;
            $display("FAIL start_timeout_pulse: got err=%0d sent=%0d want err=1 sent=0", err_cnt - e0, sent_cnt - s0);
        end
        checks++;
        if ({busy, ps2_clock, ps2_data} !== 3'b011) begin
            errors++;
            $display("FAIL start_timeout_idle: got busy/clk/data=%b want 011", {busy, ps2_clock, ps2_data});
        end
    endtask

    task automatic test_xfer_timeout;
        logic [9:0] seen;
        logic ok;
        int n, s0, e0;
        s0 = sent_cnt;
        e0 = err_cnt;
        send(8'($urandom));
        device_run(5, 1'b1, seen, ok);
        n = 0;
        while (err_cnt == e0 && sent_cnt == s0 && n < 3000) begin
            n++;
            @(negedge inclock);
        end
        repeat (3) @(negedge inclock);
        checks++;
        if (err_cnt - e0 != 1 || sent_cnt != s0) begin
            errors++;
            $display("FAIL xfer_timeout_pulse: got err=%0d sent=%0d want err=1 sent=0", err_cnt - e0, sent_cnt - s0);
        end
        checks++;
        if ({busy, ps2_clock, ps2_data} !== 3'b011) begin
            errors++;
            $display("FAIL xfer_timeout_idle: got busy/clk/data=%b want 011", {busy, ps2_clock, ps2_data});
        end
    endtask

    task automatic test_bad_ack;
        logic [9:0] seen;
        logic [7:0] c;
        logic ok;
        int n, s0, e0;
        c = 8'($urandom);
        s0 = sent_cnt;
        e0 = err_cnt;
        send(c);
        device_run(11, 1'b0, seen, ok);
        checks++;
        if (seen !== frame_bits(c)) begin
            errors++;
            $display("FAIL bad_ack_frame cmd=%h: got %b want %b", c, seen, frame_bits(c));
        end
        n = 0;
        while (err_cnt == e0 && sent_cnt == s0 && n < 500) begin
            n++;
            @(negedge inclock);
        end
        repeat (3) @(negedge inclock);
        checks++;
        if (err_cnt - e0 != 1 || sent_cnt != s0) begin
            errors++;
            $display("FAIL bad_ack_pulse: got err=%0d sent=%0d want err=1 sent=0", err_cnt - e0, sent_cnt - s0);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] seen;
        logic [7:0] c1;
        logic ok, b, any_busy;
        int n, w, s0, e0;
        c1 = 8'($urandom);
        s0 = sent_cnt;
        e0 = err_cnt;
        b = 1'b0;
        send(c1);
        fork
            device_run(11, 1'b1, seen, ok);
            begin
                w = 0;
                while (dev_clk_low !== 1'b1 && w < 10000) begin
                    w++;
                    @(negedge inclock);
                end
                repeat (4) @(negedge inclock);
                b = busy;
                send(~c1);
            end
        join
        checks++;
        if (b !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy_mid: got %b want 1", b);
        end
        checks++;
        if (seen !== frame_bits(c1)) begin
            errors++;
            $display("FAIL b2b_frame cmd=%h: got %b want %b", c1, seen, frame_bits(c1));
        end
        n = 0;
        while (sent_cnt == s0 && err_cnt == e0 && n < 500) begin
            n++;
            @(negedge inclock);
        end
        any_busy = 1'b0;
        repeat (200) begin
            @(negedge inclock);
            any_busy |= busy | ~ps2_clock;
        end
        checks++;
        if (sent_cnt - s0 != 1 || err_cnt != e0) begin
            errors++;
            $display("FAIL b2b_pulses: got sent=%0d err=%0d want sent=1 err=0", sent_cnt - s0, err_cnt - e0);
        end
        checks++;
        if (any_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_second: got activity=%b want 0", any_busy);
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] seen;
        logic ok;
        send(8'hED);
        device_run(2, 1'b1, seen, ok);
        checks++;
        if (ps2_data !== 1'b0) begin
            errors++;
            $display("FAIL mid_data_bit1: got %b want 0", ps2_data);
        end
        @(negedge inclock);
        #3 resetn = 1'b0;
        #1;
        checks++;
        if ({busy, ps2_clock, ps2_data} !== 3'b011) begin
            errors++;
            $display("FAIL async_reset_release: got busy/clk/data=%b want 011", {busy, ps2_clock, ps2_data});
        end
        @(negedge inclock);
        resetn = 1'b1;
        repeat (3) @(negedge inclock);
        test_command(8'($urandom), 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish want finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_command(8'hED, 1'b1);
        test_command(8'hF4, 1'b1);
        test_random();
        test_start_timeout();
        test_xfer_timeout();
        test_bad_ack();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL pulse_overlap: got %0d cycles want 0", overlap);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
